// File: rtl/bb_framer.sv
// Transmit framer for the Manchester baseband link: emits sync byte, payload
// bytes and a CRC-8 trailer, one bit per bit_en strobe.
module bb_framer #(
    parameter int         PAYLOAD_BYTES = 8,
    parameter logic [7:0] SYNC          = 8'h7F,
    parameter logic [7:0] CRC_POLY      = 8'h9B,
    parameter logic [7:0] CRC_INIT      = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_bit,
    output logic       frame_start,
    output logic       busy,
    output logic       underrun
);

    localparam int BW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_CRC} state_t;

    state_t          state_q, state_d;
    logic [2:0]      bitCnt_q, bitCnt_d;
    logic [BW-1:0]   byteCnt_q, byteCnt_d;
    logic [6:0]      shift_q, shift_d;
    logic [7:0]      crc_q, crc_d;
    logic            txBit_q, txBit_d;
    logic            frameStart_q, frameStart_d;
    logic            underrun_q, underrun_d;
    logic            startFrame, loadByte;
    logic [7:0]      payload;

    function automatic logic [7:0] crcStep(input logic [7:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[7];
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    always_comb begin
        state_d      = state_q;
        bitCnt_d     = bitCnt_q;
        byteCnt_d    = byteCnt_q;
        shift_d      = shift_q;
        crc_d        = crc_q;
        txBit_d      = txBit_q;
        frameStart_d = 1'b0;
        underrun_d   = 1'b0;
        in_ready     = 1'b0;
        startFrame   = 1'b0;
        loadByte     = 1'b0;
        payload      = in_valid ? in_data : 8'h00;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    startFrame = in_valid;
                    txBit_d    = 1'b0;
                end
                S_SYNC: begin
                    if (bitCnt_q == 3'd7) begin
                        in_ready  = 1'b1;
                        loadByte  = 1'b1;
                        byteCnt_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        txBit_d  = shift_q[0];
                        shift_d  = {1'b0, shift_q[6:1]};
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
                S_DATA: begin
                    if (bitCnt_q == 3'd7 && byteCnt_q == LAST_BYTE) begin
                        txBit_d  = crc_q[7];
                        crc_d    = {crc_q[6:0], 1'b0};
                        bitCnt_d = 3'd0;
                        state_d  = S_CRC;
                    end else if (bitCnt_q == 3'd7) begin
                        in_ready  = 1'b1;
                        loadByte  = 1'b1;
                        byteCnt_d = byteCnt_q + BW'(1);
                    end else begin
                        txBit_d  = shift_q[0];
                        shift_d  = {1'b0, shift_q[6:1]};
                        crc_d    = crcStep(crc_q, shift_q[0]);
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
                S_CRC: begin
                    if (bitCnt_q == 3'd7) begin
                        startFrame = in_valid;
                        txBit_d    = 1'b0;
                        bitCnt_d   = 3'd0;
                        state_d    = S_IDLE;
                    end else begin
                        txBit_d  = crc_q[7];
                        crc_d    = {crc_q[6:0], 1'b0};
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A missing byte is replaced by zeros so the frame keeps its length.
        if (loadByte) begin
            txBit_d    = payload[0];
            shift_d    = payload[7:1];
            crc_d      = crcStep(crc_q, payload[0]);
            bitCnt_d   = 3'd0;
            underrun_d = ~in_valid;
        end

        if (startFrame) begin
            state_d      = S_SYNC;
            bitCnt_d     = 3'd0;
            byteCnt_d    = '0;
            txBit_d      = SYNC[0];
            shift_d      = SYNC[7:1];
            crc_d        = CRC_INIT;
            frameStart_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bitCnt_q     <= 3'd0;
            byteCnt_q    <= '0;
            shift_q      <= 7'd0;
            crc_q        <= CRC_INIT;
            txBit_q      <= 1'b0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            byteCnt_q    <= byteCnt_d;
            shift_q      <= shift_d;
            crc_q        <= crc_d;
            txBit_q      <= txBit_d;
            frameStart_q <= frameStart_d;
            underrun_q   <= underrun_d;
        end
    end

    assign tx_bit      = txBit_q;
    assign frame_start = frameStart_q;
    assign underrun    = underrun_q;
    assign busy        = (state_q != S_IDLE);

endmodule
